// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/writeback slice:
// opcodes, instruction layout, FSM state encoding.
package alu_issue_pkg;

  localparam int IW = 16;
  localparam int RW = 3;
  localparam int IMM9_W = 9;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_NOT = 4'd10;
  localparam logic [3:0] OP_LDI = 4'd15;

  // Field layout, MSB first:
  // [15:12] oper [11:9] rd [8:6] ra
  // [5:3] rb/imm3 [2] use_imm [1:0] rsvd
  typedef struct packed {
    logic [3:0]    oper;
    logic [RW-1:0] rd;
    logic [RW-1:0] ra;
    logic [RW-1:0] rb;
    logic          use_imm;
    logic [1:0]    rsvd;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_t;

  // LDI reuses the low nine bits as imm9.
  function automatic logic [IMM9_W-1:0]
    f_imm9(input instr_t i);
    return {i.ra, i.rb, i.use_imm, i.rsvd};
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// NREGS x DW register file: two read ports, debug read,
// one write port (R0 guarded), async clear.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int DW    = 16,
  parameter int NREGS = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [RW-1:0] i_ra,
  input  logic [RW-1:0] i_rb,
  input  logic [RW-1:0] i_dbg,
  output logic [DW-1:0] o_ra_data,
  output logic [DW-1:0] o_rb_data,
  output logic [DW-1:0] o_dbg_data,
  input  logic          i_we,
  input  logic [RW-1:0] i_wa,
  input  logic [DW-1:0] i_wd
);

  logic [DW-1:0] r_mem [NREGS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_ra_data =
    (i_ra == '0) ? '0 : r_mem[i_ra];
  assign o_rb_data =
    (i_rb == '0) ? '0 : r_mem[i_rb];
  assign o_dbg_data =
    (i_dbg == '0) ? '0 : r_mem[i_dbg];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage around a registered 16-bit ALU.
// Ports: instr handshake, alu_* drive, wb_* report, dbg read.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DW    = 16,
  parameter int NREGS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [IW-1:0] instr,
  output logic          alu_en,
  output logic [3:0]    alu_oper,
  output logic [DW-1:0] alu_opa,
  output logic [DW-1:0] alu_opb,
  input  logic [DW-1:0] alu_q,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  input  logic [RW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t        r_state;
  state_t        w_next;
  instr_t        w_ins;
  logic          w_acc;
  logic          w_is_ldi;
  logic          w_is_alu;
  logic          w_wb;
  logic [DW-1:0] w_ra_data;
  logic [DW-1:0] w_rb_data;
  logic [DW-1:0] w_wb_data;

  logic          r_alu_en;
  logic [3:0]    r_alu_oper;
  logic [DW-1:0] r_alu_opa;
  logic [DW-1:0] r_alu_opb;
  logic [RW-1:0] r_rd;
  logic          r_ldi;
  logic [DW-1:0] r_imm;

  assign w_ins       = instr_t'(instr);
  assign instr_ready = rst_n && (r_state == S_IDLE);
  assign w_acc       = instr_valid && instr_ready;
  assign w_is_ldi    = (w_ins.oper == OP_LDI);
  assign w_is_alu    = (w_ins.oper != OP_NOP) &&
                       !w_is_ldi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          unique case (1'b1)
            w_is_ldi: w_next = S_WB;
            w_is_alu: w_next = S_ISSUE;
            default:  w_next = S_IDLE;
          endcase
        end
      end
      S_ISSUE: w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operands are captured at accept; the ALU
  // drive stays put until the next ALU issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_en   <= 1'b0;
      r_alu_oper <= '0;
      r_alu_opa  <= '0;
      r_alu_opb  <= '0;
      r_rd       <= '0;
      r_ldi      <= 1'b0;
      r_imm      <= '0;
    end else begin
      r_alu_en <= w_acc && w_is_alu;
      if (w_acc && w_is_alu) begin
        r_alu_oper <= w_ins.oper;
        r_alu_opa  <= w_ra_data;
        r_alu_opb  <= w_ins.use_imm ?
                      DW'(w_ins.rb) : w_rb_data;
        r_rd       <= w_ins.rd;
        r_ldi      <= 1'b0;
      end
      if (w_acc && w_is_ldi) begin
        r_rd  <= w_ins.rd;
        r_ldi <= 1'b1;
        r_imm <= DW'(f_imm9(w_ins));
      end
    end
  end

  assign w_wb      = (r_state == S_WB);
  assign w_wb_data = r_ldi ? r_imm : alu_q;

  assign alu_en   = r_alu_en;
  assign alu_oper = r_alu_oper;
  assign alu_opa  = r_alu_opa;
  assign alu_opb  = r_alu_opb;
  assign wb_valid = w_wb;
  assign wb_rd    = w_wb ? r_rd : '0;
  assign wb_data  = w_wb ? w_wb_data : '0;

  alu_regfile #(
    .DW    (DW),
    .NREGS (NREGS)
  ) u_rf (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ra       (w_ins.ra),
    .i_rb       (w_ins.rb),
    .i_dbg      (dbg_addr),
    .o_ra_data  (w_ra_data),
    .o_rb_data  (w_rb_data),
    .o_dbg_data (dbg_data),
    .i_we       (w_wb),
    .i_wa       (r_rd),
    .i_wd       (w_wb_data)
  );

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue with a cycle-level
// reference model and a behavioural ALU.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic        alu_en;
  logic [3:0]  alu_oper;
  logic [15:0] alu_opa;
  logic [15:0] alu_opb;
  logic [15:0] alu_q = '0;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue #(.DW(16), .NREGS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_en      (alu_en),
    .alu_oper    (alu_oper),
    .alu_opa     (alu_opa),
    .alu_opb     (alu_opb),
    .alu_q       (alu_q),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_ref(
    input logic [3:0] op,
    input logic [15:0] a,
    input logic [15:0] b);
    logic [15:0] r;
    logic [3:0]  s;
    s = b[3:0];
    case (op)
      4'd1:  r = a + b;
      4'd2:  r = b - a;
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = a ^ b;
      4'd6:  r = a >> b;
      4'd7:  r = a << b;
      4'd8:  r = (a >> s) | (a << (16 - s));
      4'd9:  r = (a << s) | (a >> (16 - s));
      4'd10: r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // The ALU the stage talks to: registered result.
  always @(posedge clk)
    if (alu_en)
      alu_q <= alu_ref(alu_oper, alu_opa, alu_opb);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Reference model: architectural registers plus
  // the cycle numbers at which effects must show.
  logic [15:0] M [8];
  int   cyc = 0;
  int   free = 0;
  bit   pend_en = 0;
  bit   pend_wb = 0;
  int   en_cyc, wb_cyc;
  logic [3:0]  e_oper;
  logic [15:0] e_opa, e_opb, e_data;
  logic [2:0]  e_rd;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) M[i] = '0;
    pend_en = 0;
    pend_wb = 0;
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    logic [3:0] op;
    logic [15:0] a, b;
    if (!rst_n) begin
      free = cyc + 1;
    end else begin
      if (pend_wb && wb_cyc == cyc) begin
        if (e_rd != 0) M[e_rd] = e_data;
        pend_wb = 0;
      end
      if (instr_valid && cyc >= free) begin
        op = instr[15:12];
        if (op == 4'd15) begin
          pend_wb = 1;
          wb_cyc  = cyc + 1;
          e_rd    = instr[11:9];
          e_data  = {7'd0, instr[8:0]};
          free    = cyc + 2;
        end else if (op != 4'd0) begin
          a = M[instr[8:6]];
          b = instr[2] ? {13'd0, instr[5:3]}
                       : M[instr[5:3]];
          pend_en = 1;
          en_cyc  = cyc + 1;
          e_oper  = op;
          e_opa   = a;
          e_opb   = b;
          pend_wb = 1;
          wb_cyc  = cyc + 2;
          e_rd    = instr[11:9];
          e_data  = alu_ref(op, a, b);
          free    = cyc + 3;
        end
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    bit x_en, x_wb;
    x_en = rst_n && pend_en && en_cyc == cyc;
    x_wb = rst_n && pend_wb && wb_cyc == cyc;
    chk("instr_ready", instr_ready,
        rst_n && cyc >= free);
    chk("alu_en", alu_en, x_en);
    chk("wb_valid", wb_valid, x_wb);
    chk("dbg_data", dbg_data, M[dbg_addr]);
    if (x_en) begin
      chk("alu_oper", alu_oper, e_oper);
      chk("alu_opa", alu_opa, e_opa);
      chk("alu_opb", alu_opb, e_opb);
    end
    if (x_wb) begin
      chk("wb_rd", wb_rd, e_rd);
      chk("wb_data", wb_data, e_data);
    end
    if (!rst_n) begin
      chk("rst_oper", alu_oper, 0);
      chk("rst_opa", alu_opa, 0);
      chk("rst_opb", alu_opb, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);
    end
  end

  function automatic logic [15:0] mk(
    input int op, input int rd, input int ra,
    input int rb, input int imm);
    logic [15:0] v;
    v = {op[3:0], rd[2:0], ra[2:0],
         rb[2:0], imm[0], 2'b00};
    return v;
  endfunction

  function automatic logic [15:0] ldi(
    input int rd, input int imm9);
    logic [15:0] v;
    v = {4'hF, rd[2:0], imm9[8:0]};
    return v;
  endfunction

  // Called at posedge+2; returns at posedge+2
  // just after the accept edge.
  task automatic issue(input logic [15:0] ins,
                       input int gap);
    bit r;
    int n;
    repeat (gap) begin
      @(posedge clk); #2;
      instr_valid = 1'b0;
      instr = 16'($urandom);
      dbg_addr = 3'($urandom);
    end
    instr_valid = 1'b1;
    instr = ins;
    n = 0;
    do begin
      @(negedge clk);
      r = instr_ready;
      @(posedge clk); #2;
      dbg_addr = 3'($urandom);
      n++;
    end while (!r && n < 30);
    if (!r) chk("accept_timeout", r, 1);
    instr_valid = 1'b0;
    instr = 16'($urandom);
  endtask

  task automatic chk_reg(input int idx,
                         input logic [15:0] v);
    repeat (3) begin
      @(posedge clk); #2;
    end
    dbg_addr = idx[2:0];
    #1;
    chk($sformatf("R%0d", idx), dbg_data, v);
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      chk("rst_reg", dbg_data, 0);
    end
    chk("rst_ready_low", instr_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", instr_ready, 1);
    chk("rel_en", alu_en, 0);
    chk("rel_wb", wb_valid, 0);

    issue(ldi(1, 9'h1FF), 1);
    issue(ldi(2, 9'h003), 0);
    issue(mk(1, 3, 1, 2, 0), 0);
    issue(mk(7, 4, 2, 4, 1), 0);
    issue(mk(2, 5, 2, 1, 0), 1);
    issue(ldi(0, 9'h055), 0);
    issue(mk(0, 6, 1, 2, 0), 0);
    issue(mk(12, 7, 1, 2, 0), 2);
    chk_reg(1, 16'h01FF);
    chk_reg(2, 16'h0003);
    chk_reg(3, 16'h0202);
    chk_reg(4, 16'h0030);
    chk_reg(5, 16'h01FC);
    chk_reg(0, 16'h0000);
    chk_reg(7, 16'h0000);

    // Abort an ADD while it sits in ISSUE.
    issue(mk(1, 6, 1, 2, 0), 1);
    #1;
    chk("abort_en_before", alu_en, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_en", alu_en, 0);
    chk("abort_wb", wb_valid, 0);
    repeat (2) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b1;
    chk_reg(6, 16'h0000);
    issue(ldi(1, 9'h0AB), 1);
    issue(mk(1, 6, 1, 1, 0), 0);
    chk_reg(6, 16'h0156);

    for (int k = 0; k < 500; k++) begin
      issue(16'($urandom),
            int'($urandom_range(0, 3)));
    end
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
